// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store.
// Data wins contention; after MAX_DSTREAK contended data grants, fetch gets a turn.
//
//   state  | meaning
//   IDLE   | no access outstanding; arbitrating i_req/d_req every cycle
//   BUSY_I | fetch access issued; waiting for m_ack
//   BUSY_D | load/store access issued; waiting for m_ack
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata
);

  localparam int BW = DW / 8;
  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          grant_i, grant_d;
  logic          fetch_turn;

  assign fetch_turn = (dstreak_q == SW'(MAX_DSTREAK));

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_rvalid  = 1'b0;
    d_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && fetch_turn)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
          // streak only grows while fetch is actually waiting
          if (i_req)
            dstreak_d = fetch_turn ? dstreak_q : dstreak_q + SW'(1);
          else
            dstreak_d = '0;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_d   = BUSY_I;
          dstreak_d = '0;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          i_rvalid = 1'b1;
          state_d  = IDLE;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  // memory-side outputs are latched at grant and held until the ack edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else if (grant_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_be;
    end else if (grant_i) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_be    <= {BW{1'b1}};
    end else if (state_q != IDLE && m_ack) begin
      m_req   <= 1'b0;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected accesses,
// a monitor pops and checks them whenever i_rvalid or d_done fires.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_ack;
  logic [DW-1:0] m_rdata = '0;

  logic mem_ack = 1'b0;
  logic spur_ack = 1'b0;
  assign m_ack = mem_ack | spur_ack;

  int n_pass = 0;
  int n_total = 0;
  int ack_delay = 0;
  int ack_cnt = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic void push(input logic is_d, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                               input logic [DW-1:0] rdata);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  // memory model: acks ack_delay cycles after m_req is seen, applies writes with byte enables
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else begin
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (m_req) begin
        if (ack_cnt == ack_delay) begin
          if (m_we) begin
            logic [DW-1:0] v;
            v = mem.exists(m_addr) ? mem[m_addr] : '0;
            for (int b = 0; b < BW; b++)
              if (m_be[b]) v[8*b +: 8] = m_wdata[8*b +: 8];
            mem[m_addr] = v;
            m_rdata = '0;
          end else begin
            m_rdata = mem.exists(m_addr) ? mem[m_addr] : '0;
          end
          mem_ack = 1'b1;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && (i_rvalid || d_done)) begin
      chk("strobe_exclusive", 64'(i_rvalid & d_done), 64'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: i_rvalid=%0b d_done=%0b required no strobe", i_rvalid, d_done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_kind_is_d", 64'(d_done), 64'(mon_e.is_d));
        chk("m_req_at_ack", 64'(m_req), 64'd1);
        chk("m_addr", 64'(m_addr), 64'(mon_e.addr));
        chk("m_we", 64'(m_we), 64'(mon_e.we));
        chk("m_be", 64'(m_be), 64'(mon_e.be));
        if (mon_e.is_d && mon_e.we) chk("m_wdata", 64'(m_wdata), 64'(mon_e.wdata));
        if (!mon_e.we) chk("rdata", 64'(d_done ? d_rdata : i_rdata), 64'(mon_e.rdata));
      end
    end
  end

  // waits for the requester's strobe, then returns just after the ack edge
  task automatic wait_strobe(input bit is_d, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? d_done : i_rvalid;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_timeout: strobe not seen within 200 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [BW-1:0] be, input string name);
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    wait_strobe(1'b1, name);
    d_req = 1'b0;
  endtask

  task automatic do_i(input logic [AW-1:0] addr, input string name);
    @(posedge clk);
    #1;
    i_req = 1'b1; i_addr = addr;
    wait_strobe(1'b0, name);
    i_req = 1'b0;
  endtask

  task automatic wait_m_req(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = m_req;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_timeout: m_req not seen within 50 cycles", name);
    end
  endtask

  initial begin
    mem[32'h100]  = 32'h0050_0093;
    mem[32'h2000] = 32'h1122_3344;
    mem[32'h300]  = 32'hD000_0300;
    mem[32'h304]  = 32'hD000_0304;
    mem[32'h308]  = 32'hD000_0308;
    mem[32'h30C]  = 32'hD000_030C;
    mem[32'h400]  = 32'h1000_0400;
    mem[32'h404]  = 32'h1000_0404;
    mem[32'h40]   = 32'hCAFE_0040;
    mem[32'h80]   = 32'hBAD0_0080;
    mem[32'h600]  = 32'h1234_5678;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({m_req, m_we, m_be}), 64'd0);
    chk("reset_m_addr", 64'(m_addr), 64'd0);
    chk("reset_m_wdata", 64'(m_wdata), 64'd0);
    chk("reset_strobes", 64'({i_rvalid, d_done}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // reset while a store is outstanding: abandoned, never written, no d_done
    ack_delay = 20;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h5555_5555; d_be = 4'hF;
    wait_m_req("reset_busy");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mid_m_req", 64'(m_req), 64'd0);
    chk("reset_mid_d_done", 64'(d_done), 64'd0);
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_ctrl", 64'({m_req, m_we, m_be}), 64'd0);
    chk("post_reset_m_addr", 64'(m_addr), 64'd0);
    chk("post_reset_m_wdata", 64'(m_wdata), 64'd0);
    chk("reset_no_write", 64'(mem.exists(32'h500)), 64'd0);

    // single fetch, ack two cycles after m_req
    ack_delay = 2;
    push(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0050_0093);
    do_i(32'h100, "fetch");

    // partial store followed by a load of the merged word
    ack_delay = 1;
    push(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 32'h0);
    do_d(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, "store");
    push(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h1122_BEEF);
    do_d(1'b0, 32'h2000, 32'h0, 4'h0, "load_merged");

    // contention with immediate ack: expected grant order D D I D D I
    ack_delay = 0;
    push(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'hD000_0300);
    push(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 32'hD000_0304);
    push(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h1000_0400);
    push(1'b1, 1'b0, 32'h308, 32'h0, 4'h0, 32'hD000_0308);
    push(1'b1, 1'b0, 32'h30C, 32'h0, 4'h0, 32'hD000_030C);
    push(1'b0, 1'b0, 32'h404, 32'h0, 4'hF, 32'h1000_0404);
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'h0;
    i_req = 1'b1; i_addr = 32'h400;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          wait_strobe(1'b1, "contend_d");
          if (k < 3) d_addr = 32'h300 + 32'(4 * (k + 1));
          else d_req = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_strobe(1'b0, "contend_i");
          if (k == 0) i_addr = 32'h404;
          else i_req = 1'b0;
        end
      end
    join

    // requester address changes while busy must not reach memory
    ack_delay = 3;
    push(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFE_0040);
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'h0;
    wait_m_req("busy_hold");
    d_addr = 32'h80;
    @(negedge clk);
    chk("busy_m_addr_held", 64'(m_addr), 64'h40);
    wait_strobe(1'b1, "busy_hold");
    d_req = 1'b0;

    // spurious ack while idle, then a normal load
    @(negedge clk);
    spur_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_m_req", 64'(m_req), 64'd0);
      chk("spur_strobes", 64'({i_rvalid, d_done}), 64'd0);
    end
    spur_ack = 1'b0;
    ack_delay = 1;
    push(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 32'h1234_5678);
    do_d(1'b0, 32'h600, 32'h0, 4'h0, "load_after_spur");

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch requester and its load/store requester.
- Serialises the two requesters, one outstanding transaction at a time.
- Returns read data and completion strobes to the winning requester.
- Data accesses have priority; a streak counter prevents instruction-fetch starvation.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- MAX_DSTREAK, 2, number of consecutive contended data grants after which fetch must win; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_req  input  1  fetch request; level, held until i_rvalid.
- i_addr  input  AW  fetch address; stable while i_req=1.
- i_rvalid  output  1  fetch data valid; one-cycle pulse.
- i_rdata  output  DW  fetch data; valid only when i_rvalid=1.
- d_req  input  1  data request; level, held until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_be  input  DW/8  store byte enables.
- d_done  output  1  data access complete; one-cycle pulse.
- d_rdata  output  DW  load data; valid only when d_done=1 and the access was a load.
- m_req  output  1  memory request; registered.
- m_we  output  1  memory write enable; registered.
- m_addr  output  AW  memory address; registered.
- m_wdata  output  DW  memory write data; registered.
- m_be  output  DW/8  memory byte enables; registered.
- m_ack  input  1  memory completion; read data valid or write done.
- m_rdata  input  DW  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, dstreak=0.
  - m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0.
  - i_rvalid=0, d_done=0.
  - Reset mid-transaction abandons the access; no done/rvalid is produced for it. Memory is reset by the same reset.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration (evaluated every cycle in IDLE):
  - d_req only → grant D.
  - i_req only → grant I.
  - both → grant I if dstreak==MAX_DSTREAK, else grant D.
  - neither → stay in IDLE.
- On grant:
  - Latch the winner's address into m_addr, and for D also m_we/m_wdata/m_be.
  - For I: m_we=0, m_be=all-ones, m_wdata unchanged.
  - Set m_req=1 and go to BUSY_I or BUSY_D. m_req rises the cycle after the grant decision (1-cycle issue latency).
- dstreak update, only on a grant:
  - Contended D grant (i_req=1): dstreak saturating +1.
  - Any I grant: dstreak←0.
  - Uncontended D grant: dstreak←0.
- BUSY_x:
  - m_req and all m_* outputs are held constant until m_ack=1.
  - On m_ack: the corresponding strobe is asserted combinationally in that same cycle (i_rvalid=1 with i_rdata=m_rdata, or d_done=1 with d_rdata=m_rdata).
  - On m_ack: m_req←0 and state←IDLE at the next edge.
  - Requester inputs changing while BUSY are ignored; only latched values reach memory.
- Handshake rule: a requester's req in the cycle after its done/rvalid is treated as a new request. A requester with no further work must drop req in that cycle.
- Back-to-back throughput: minimum 2 cycles per access (grant cycle + ack cycle, m_ack same cycle as m_req).
- m_ack in IDLE is ignored (no strobe, no state change).
- i_rvalid and d_done are never both 1. Neither is 1 outside its own BUSY state.
- i_rdata and d_rdata may be driven as m_rdata unconditionally; consumers qualify with the strobes.

Test Plan:
1. Reset with reset=0 while BUSY_D mid-access → next cycle m_req=0, no d_done; after release with no requests, state stays IDLE and all m_* are 0.
2. Single fetch: i_req=1, i_addr=0x100; memory acks 2 cycles after m_req with m_rdata=0x00500093 → m_addr=0x100, m_we=0, m_be=0xF; i_rvalid=1 exactly one cycle, i_rdata=0x00500093.
3. Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3 → m_we=1, m_wdata=0xDEADBEEF, m_be=0x3; d_done pulses on m_ack; i_rvalid stays 0.
4. Contention, MAX_DSTREAK=2, i_req and d_req held high, data requester re-requesting continuously, m_ack immediate → grant order D, D, I, D, D, I.
5. Inputs change while BUSY: d_addr switches 0x40→0x80 during BUSY_D → m_addr remains 0x40 until ack.
6. Spurious m_ack=1 while IDLE with no requests → no strobe, state stays IDLE; then d_req load with m_rdata=0x12345678 → d_done=1, d_rdata=0x12345678.
